// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// MULT/MULTU/DIV/DIVU take WIDTH+1 busy cycles; MTHI/MTLO/MFHI/MFLO complete in one.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [5:0] FUN_MFHI  = 6'h10;
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MFLO  = 6'h12;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;
  localparam int         CW        = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_prod;    // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     r_opd;     // multiplicand or divisor magnitude
  logic                 r_is_div;
  logic                 r_neg_lo;  // negate product (mul) or quotient (div)
  logic                 r_neg_hi;  // negate remainder
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_last;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;

  assign w_is_mul = (funct == FUN_MULT) || (funct == FUN_MULTU);
  assign w_is_div = (funct == FUN_DIV)  || (funct == FUN_DIVU);
  assign w_signed = (funct == FUN_MULT) || (funct == FUN_DIV);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_last   = (r_count == CW'(WIDTH - 1));

  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opd} : '0);
  assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

  // A set top bit means the shifted remainder already exceeds any WIDTH-bit divisor.
  assign w_shift    = r_prod[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_shift - {1'b0, r_opd};
  assign w_ge       = w_shift[WIDTH] | ~w_diff[WIDTH];
  assign w_div_next = w_ge ? {w_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1}
                           : {w_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};

  assign w_prod_fix = r_neg_lo ? -r_prod : r_prod;
  assign w_q_fix    = r_neg_lo ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_r_fix    = r_neg_hi ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next = S_MUL;
        else if (w_accept && w_is_div) w_next = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_next = S_FIX;
      S_FIX:        w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_prod   <= '0;
      r_opd    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_count <= '0;
            if (funct == FUN_MTHI) r_hi <= a;
            if (funct == FUN_MTLO) r_lo <= a;
            if (w_is_mul) begin
              r_is_div <= 1'b0;
              r_prod   <= {{WIDTH{1'b0}}, w_b_mag};
              r_opd    <= w_a_mag;
              r_neg_lo <= w_a_neg ^ w_b_neg;
              r_neg_hi <= 1'b0;
            end else if (w_is_div && (b == '0)) begin
              // Zero divisor: every step accepts, so the raw dividend migrates into HI and LO fills with ones.
              r_is_div <= 1'b1;
              r_prod   <= {{WIDTH{1'b0}}, a};
              r_opd    <= '0;
              r_neg_lo <= 1'b0;
              r_neg_hi <= 1'b0;
            end else if (w_is_div) begin
              r_is_div <= 1'b1;
              r_prod   <= {{WIDTH{1'b0}}, w_a_mag};
              r_opd    <= w_b_mag;
              r_neg_lo <= w_a_neg ^ w_b_neg;
              r_neg_hi <= w_a_neg;
            end
          end
        end
        S_MUL: begin
          r_prod  <= w_mul_next;
          r_count <= r_count + 1'b1;
        end
        S_DIV: begin
          r_prod  <= w_div_next;
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          if (!flush) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_r_fix;
              r_lo <= w_q_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign rdata = (funct == FUN_MFHI) ? r_hi :
                 (funct == FUN_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, flush/reset/busy
// behaviour and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (f)
      F_MULT:  ref_result = 64'(sx * sy);
      F_MULTU: ref_result = ux * uy;
      F_DIV, F_DIVU: begin
        if (y == 32'd0) ref_result = {x, 32'hFFFF_FFFF};
        else if (f == F_DIV) begin
          q = sx / sy;
          r = sx % sy;
          ref_result = {r[31:0], q[31:0]};
        end else ref_result = {32'(ux % uy), 32'(ux / uy)};
      end
      default: ref_result = '0;
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       rand_opnd = 32'd0;
      1:       rand_opnd = 32'd1;
      2:       rand_opnd = 32'hFFFF_FFFF;
      3:       rand_opnd = 32'h8000_0000;
      default: rand_opnd = $urandom;
    endcase
  endfunction

  // Present a request for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
  endtask

  // Counts busy cycles (bounded) and reports whether done is high once busy drops.
  task automatic wait_done(output int cyc, output logic seen);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    seen = (done === 1'b1) && (cyc < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct = 6'h00; a = '0; b = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    logic seen;
    issue(F_MTHI, 32'h1234_5678, 32'd0);
    issue(F_MTLO, 32'h9ABC_DEF0, 32'd0);
    checks++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL mthi_mtlo got %h/%h exp 12345678/9abcdef0", hi, lo);
    end
    issue(F_DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_c10 got %b exp 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_ctl got busy=%b done=%b exp 0/0", busy, done);
    end
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL midreset_hilo got %h/%h exp 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || lo !== '0) begin
      errors++; $display("FAIL midreset_after got activity=%b lo=%h exp 0/0", seen, lo);
    end
  endtask

  typedef struct {
    logic [5:0]  f;
    logic [31:0] x, y, eh, el;
  } vec_t;

  task automatic test_directed();
    vec_t v[5];
    int   cyc;
    logic seen;
    v[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'd2,           32'd1,           32'hFFFF_FFFE};
    v[1] = '{F_MULT,  32'hFFFF_FFFD, 32'd7,           32'hFFFF_FFFF,   32'hFFFF_FFEB};
    v[2] = '{F_DIV,   32'hFFFF_FFF9, 32'd2,           32'hFFFF_FFFF,   32'hFFFF_FFFD};
    v[3] = '{F_DIVU,  32'd100,       32'd0,           32'd100,         32'hFFFF_FFFF};
    v[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF,   32'd0,           32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      issue(v[i].f, v[i].x, v[i].y);
      wait_done(cyc, seen);
      checks++; if (cyc != 33 || !seen) begin
        errors++; $display("FAIL dir%0d_latency got busy=%0d done=%b exp 33/1", i, cyc, seen);
      end
      checks++; if (hi !== v[i].eh) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, hi, v[i].eh); end
      checks++; if (lo !== v[i].el) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, lo, v[i].el); end
      funct = F_MFLO; #1;
      checks++; if (rdata !== v[i].el) begin errors++; $display("FAIL dir%0d_mflo got %h exp %h", i, rdata, v[i].el); end
      funct = F_MFHI; #1;
      checks++; if (rdata !== v[i].eh) begin errors++; $display("FAIL dir%0d_mfhi got %h exp %h", i, rdata, v[i].eh); end
      funct = F_MULT; #1;
      checks++; if (rdata !== '0) begin errors++; $display("FAIL dir%0d_rdata_other got %h exp 0", i, rdata); end
      funct = 6'h00;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b exp 0", i, done); end
    end
  endtask

  task automatic test_busy_ignore();
    int   cyc;
    logic seen;
    issue(F_DIVU, 32'd17, 32'd5);
    repeat (5) @(negedge clk);
    start = 1'b1; funct = F_MTLO; a = 32'd9;
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
    wait_done(cyc, seen);
    checks++; if (!seen || lo !== 32'd3 || hi !== 32'd2) begin
      errors++; $display("FAIL busy_ignore got done=%b hi=%h lo=%h exp 1/2/3", seen, hi, lo);
    end
    start = 1'b1; funct = F_MTHI; a = 32'd5;
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
    checks++; if (hi !== 32'd5 || lo !== 32'd3 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi_in_done got hi=%h lo=%h busy=%b done=%b exp 5/3/0/0", hi, lo, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic seen;
    issue(F_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc, seen);
    checks++; if (!seen || hi !== 32'd1 || lo !== 32'd0) begin
      errors++; $display("FAIL b2b_first got done=%b hi=%h lo=%h exp 1/1/0", seen, hi, lo);
    end
    start = 1'b1; funct = F_DIV; a = 32'hFFFF_FF9C; b = 32'd7;
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy); end
    wait_done(cyc, seen);
    checks++; if (cyc != 33 || !seen || hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin
      errors++; $display("FAIL b2b_second got cyc=%0d done=%b hi=%h lo=%h exp 33/1/fffffffe/fffffff2", cyc, seen, hi, lo);
    end
  endtask

  task automatic test_flush();
    int   cyc;
    logic seen;
    issue(F_MTHI, 32'd0, 32'd0);
    issue(F_MTLO, 32'd0, 32'd0);
    issue(F_MULT, 32'd123, 32'd456);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_mul_busy got %b exp 0", busy); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++; $display("FAIL flush_mul_after got done=%b hi=%h lo=%h exp 0/0/0", seen, hi, lo);
    end
    issue(F_MULTU, 32'd5, 32'd6);
    repeat (32) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fix_busy got %b exp 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || lo !== '0) begin
      errors++; $display("FAIL flush_fix got busy=%b done=%b lo=%h exp 0/0/0", busy, done, lo);
    end
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct = F_MULT; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; funct = 6'h00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_mul got busy=%b exp 0", busy); end
    start = 1'b1; flush = 1'b1; funct = F_MTHI; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; funct = 6'h00;
    checks++; if (hi !== '0) begin errors++; $display("FAIL start_flush_mthi got hi=%h exp 0", hi); end
    issue(F_MULTU, 32'd5, 32'd6);
    wait_done(cyc, seen);
    checks++; if (cyc != 33 || !seen || lo !== 32'd30 || hi !== 32'd0) begin
      errors++; $display("FAIL post_flush_op got cyc=%0d done=%b hi=%h lo=%h exp 33/1/0/1e", cyc, seen, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops[6];
    logic [5:0]  f;
    logic [31:0] x, y, m_hi, m_lo;
    logic [63:0] r;
    int          cyc;
    logic        seen;
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    issue(F_MTHI, 32'd0, 32'd0);
    issue(F_MTLO, 32'd0, 32'd0);
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 5)];
      x = rand_opnd();
      y = rand_opnd();
      issue(f, x, y);
      if (f == F_MTHI) m_hi = x;
      else if (f == F_MTLO) m_lo = x;
      else begin
        r = ref_result(f, x, y);
        m_hi = r[63:32];
        m_lo = r[31:0];
        wait_done(cyc, seen);
        checks++; if (cyc != 33 || !seen) begin
          errors++; $display("FAIL rnd%0d_latency op=%h got busy=%0d done=%b exp 33/1", i, f, cyc, seen);
        end
      end
      checks++; if (hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL rnd%0d_result op=%h a=%h b=%h got %h/%h exp %h/%h", i, f, x, y, hi, lo, m_hi, m_lo);
      end
      funct = F_MFHI; #1;
      checks++; if (rdata !== m_hi) begin errors++; $display("FAIL rnd%0d_mfhi got %h exp %h", i, rdata, m_hi); end
      funct = 6'h00;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_div();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
